// File: rtl/seq_check3.sv
// rtl/seq_check3.sv - receive-side lock/error checker for the 1,2,4,6,0,3,5,7 test-pattern sequence
module seq_check3 #(
  parameter int LOCK_CNT = 3,
  parameter int MISS_LIM = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       in_code,
  input  logic             clr_err,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [2:0]       index,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Counters are compared one bit wider so the +1 never wraps before the compare.
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);
  localparam logic [3:0]       MISS_N  = 4'(MISS_LIM);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  state_t     state;
  logic [2:0] exp_code;
  logic [2:0] match_cnt;
  logic [2:0] miss_cnt;

  // Code that follows c in the pattern.
  function automatic logic [2:0] nxt(input logic [2:0] c);
    case (c)
      3'd1:    nxt = 3'd2;
      3'd2:    nxt = 3'd4;
      3'd4:    nxt = 3'd6;
      3'd6:    nxt = 3'd0;
      3'd0:    nxt = 3'd3;
      3'd3:    nxt = 3'd5;
      3'd5:    nxt = 3'd7;
      default: nxt = 3'd1;
    endcase
  endfunction

  // Position of c within one period, counting from code 1.
  function automatic logic [2:0] ord(input logic [2:0] c);
    case (c)
      3'd1:    ord = 3'd0;
      3'd2:    ord = 3'd1;
      3'd4:    ord = 3'd2;
      3'd6:    ord = 3'd3;
      3'd0:    ord = 3'd4;
      3'd3:    ord = 3'd5;
      3'd5:    ord = 3'd6;
      default: ord = 3'd7;
    endcase
  endfunction

  logic hit;
  assign hit = (in_code == exp_code);

  // Hunt/sync/locked tracker with registered status outputs and error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      locked    <= 1'b0;
      err       <= 1'b0;
      wrap      <= 1'b0;
      index     <= 3'd0;
      err_count <= '0;
      exp_code  <= 3'd0;
      match_cnt <= 3'd0;
      miss_cnt  <= 3'd0;
    end else begin
      err  <= 1'b0;
      wrap <= 1'b0;
      if (clr_err) begin
        err_count <= '0;
      end
      if (in_valid) begin
        index <= ord(in_code);
        case (state)
          HUNT: begin
            exp_code  <= nxt(in_code);
            match_cnt <= 3'd0;
            state     <= SYNC;
          end
          SYNC: begin
            exp_code <= nxt(in_code);
            if (hit) begin
              match_cnt <= match_cnt + 3'd1;
              if ({1'b0, match_cnt} + 4'd1 == LOCK_N) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= 3'd0;
              end
            end else begin
              // Resync on the received value; no error is reported before lock.
              match_cnt <= 3'd0;
            end
          end
          LOCKED: begin
            if (hit) begin
              exp_code <= nxt(in_code);
              miss_cnt <= 3'd0;
              wrap     <= (in_code == 3'd1);
            end else begin
              err <= 1'b1;
              if (!clr_err && err_count != ERR_MAX) begin
                err_count <= err_count + ERR_ONE;
              end
              // Flywheel: keep following the nominal sequence across a bad sample.
              exp_code <= nxt(exp_code);
              miss_cnt <= miss_cnt + 3'd1;
              if ({1'b0, miss_cnt} + 4'd1 == MISS_N) begin
                state  <= HUNT;
                locked <= 1'b0;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_check3.sv
// tb/tb_seq_check3.sv - scoreboard bench for seq_check3
module tb_seq_check3;

  localparam int ERR_W = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [2:0]       in_code;
  logic             clr_err;
  logic             locked;
  logic             err;
  logic             wrap;
  logic [2:0]       index;
  logic [ERR_W-1:0] err_count;

  typedef struct {
    logic             l;
    logic             e;
    logic             w;
    logic [2:0]       i;
    logic [ERR_W-1:0] c;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   vec   = 0;

  seq_check3 #(.LOCK_CNT(3), .MISS_LIM(2), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .clr_err   (clr_err),
    .locked    (locked),
    .err       (err),
    .wrap      (wrap),
    .index     (index),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0d want=%0d", name, vec, got, want);
    end
  endtask

  // Drive one vector at the falling edge and queue what should appear after the next rising edge.
  task automatic step(input logic v, input logic [2:0] code, input logic clr,
                      input logic l, input logic e, input logic w,
                      input logic [2:0] i, input logic [ERR_W-1:0] c);
    exp_t x;
    @(negedge clk);
    in_valid = v;
    in_code  = code;
    clr_err  = clr;
    x.l = l; x.e = e; x.w = w; x.i = i; x.c = c;
    q.push_back(x);
  endtask

  // Monitor: every rising edge with a pending expectation, compare registered outputs.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      vec++;
      check("locked",    int'(locked),    int'(x.l));
      check("err",       int'(err),       int'(x.e));
      check("wrap",      int'(wrap),      int'(x.w));
      check("index",     int'(index),     int'(x.i));
      check("err_count", int'(err_count), int'(x.c));
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_code = 3'd0; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    //    v code clr   L  E  W  I  C
    step(0, 3'd0, 0,  0, 0, 0, 0, 0);
    // clean period from reset
    step(1, 3'd1, 0,  0, 0, 0, 0, 0);
    step(1, 3'd2, 0,  0, 0, 0, 1, 0);
    step(1, 3'd4, 0,  0, 0, 0, 2, 0);
    step(1, 3'd6, 0,  1, 0, 0, 3, 0);
    step(1, 3'd0, 0,  1, 0, 0, 4, 0);
    step(1, 3'd3, 0,  1, 0, 0, 5, 0);
    step(1, 3'd5, 0,  1, 0, 0, 6, 0);
    step(1, 3'd7, 0,  1, 0, 0, 7, 0);
    step(1, 3'd1, 0,  1, 0, 1, 0, 0);
    // single bad code, flywheel keeps lock
    step(1, 3'd2, 0,  1, 0, 0, 1, 0);
    step(1, 3'd4, 0,  1, 0, 0, 2, 0);
    step(1, 3'd6, 0,  1, 0, 0, 3, 0);
    step(1, 3'd5, 0,  1, 1, 0, 6, 1);
    step(1, 3'd3, 0,  1, 0, 0, 5, 1);
    step(1, 3'd5, 0,  1, 0, 0, 6, 1);
    step(0, 3'd0, 1,  1, 0, 0, 6, 0);
    // two consecutive misses drop lock, then relock
    step(1, 3'd2, 0,  1, 1, 0, 1, 1);
    step(1, 3'd0, 0,  0, 1, 0, 4, 2);
    step(1, 3'd2, 0,  0, 0, 0, 1, 2);
    step(1, 3'd4, 0,  0, 0, 0, 2, 2);
    step(1, 3'd6, 0,  0, 0, 0, 3, 2);
    step(1, 3'd0, 0,  1, 0, 0, 4, 2);
    // gaps in in_valid
    step(1, 3'd3, 0,  1, 0, 0, 5, 2);
    step(0, 3'd4, 0,  1, 0, 0, 5, 2);
    step(0, 3'd1, 0,  1, 0, 0, 5, 2);
    step(1, 3'd5, 0,  1, 0, 0, 6, 2);
    step(0, 3'd2, 0,  1, 0, 0, 6, 2);
    step(1, 3'd7, 0,  1, 0, 0, 7, 2);
    step(0, 3'd0, 0,  1, 0, 0, 7, 2);
    step(0, 3'd6, 0,  1, 0, 0, 7, 2);
    step(1, 3'd1, 0,  1, 0, 1, 0, 2);
    step(0, 3'd1, 0,  1, 0, 0, 0, 2);
    // saturation at 3 with ERR_W=2
    step(1, 3'd7, 0,  1, 1, 0, 7, 3);
    step(1, 3'd4, 0,  1, 0, 0, 2, 3);
    step(1, 3'd7, 0,  1, 1, 0, 7, 3);
    step(1, 3'd7, 0,  0, 1, 0, 7, 3);
    step(0, 3'd0, 1,  0, 0, 0, 7, 0);
    // clr_err coincident with an err pulse
    step(1, 3'd1, 0,  0, 0, 0, 0, 0);
    step(1, 3'd2, 0,  0, 0, 0, 1, 0);
    step(1, 3'd4, 0,  0, 0, 0, 2, 0);
    step(1, 3'd6, 0,  1, 0, 0, 3, 0);
    step(1, 3'd3, 1,  1, 1, 0, 5, 0);
    step(1, 3'd3, 0,  1, 0, 0, 5, 0);
    step(1, 3'd0, 0,  1, 1, 0, 4, 1);
    // asynchronous reset between edges while locked
    @(negedge clk);
    in_valid = 1'b0; clr_err = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_locked",    int'(locked),    0);
    check("async_index",     int'(index),     0);
    check("async_err_count", int'(err_count), 0);
    rst = 1'b0;
    // first sample re-enters SYNC; lock needs three more correct successors
    step(1, 3'd5, 0,  0, 0, 0, 6, 0);
    step(1, 3'd7, 0,  0, 0, 0, 7, 0);
    step(1, 3'd1, 0,  0, 0, 0, 0, 0);
    step(1, 3'd2, 0,  1, 0, 0, 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
